inv_add_round_key: RTL and testbench
====================================

INV_ADD_ROUND_KEY -- requirements
Module: inv_add_round_key

Interface
REQ-001 Parameter: NR, 10, number of cipher rounds per block; 10, 12 or 14 are legal.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream beat present.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_first  input  1  beat is round 0 of a new block.
REQ-007 state_in  input  [0:127]  state after InvSubBytes, or ciphertext on round 0; byte 0 in bits [0:7].
REQ-008 round_key  input  [0:127]  round key for this beat, same byte order.
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 state_out  output  [0:127]  state_in XOR round_key, same byte order.
REQ-012 out_round  output  [3:0]  round index of the output beat, 0..NR.
REQ-013 out_mix  output  1  downstream InvMixColumns is applied to this beat.
REQ-014 out_last  output  1  beat is round NR, which is the plaintext.
REQ-015 err_seq  output  1  sticky sequence error.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-017 Output is delivered when out_valid and out_ready are both 1 on a rising clk edge.
REQ-018 state_out SHALL equal state_in XOR round_key bytewise, registered, with 1-cycle latency from acceptance to out_valid.
REQ-019 Round counter rc (4 bits):
- set to 0 on a beat accepted with in_first;
- otherwise incremented per accepted beat;
- after round NR it returns to the "expect first" condition.
REQ-020 out_round is the rc value of that beat.
- out_mix = 1 iff 1 <= out_round <= NR-1.
- out_last = 1 iff out_round == NR.
REQ-021 States: IDLE (expect in_first) and BUSY (rounds 1..NR pending).
- IDLE->BUSY on an accepted in_first beat.
- BUSY->IDLE on acceptance of round NR.
REQ-022 In IDLE, a beat accepted without in_first SHALL still pass through as round 0 and SHALL set err_seq.
REQ-023 In BUSY, a beat accepted with in_first SHALL restart rc at 0 and SHALL set err_seq.
REQ-024 Output fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous acceptance and delivery in the same cycle SHALL sustain 1 beat/cycle with no bubble and no loss.
REQ-026 No beat is dropped or duplicated under any valid/ready pattern.

Reset
REQ-027 While rst_n=0, regardless of clk, all outputs SHALL be 0:
- out_valid=0, in_ready=0, state_out=0, out_round=0, out_mix=0, out_last=0, err_seq=0;
- FSM=IDLE, rc=0.
REQ-028 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Reset mid-block discards all buffered beats and returns to IDLE.
REQ-030 err_seq clears only on reset.

Configuration
REQ-031 Macro INV_ARK_SKID_EN.
- Defined: a 2-entry skid buffer is compiled in. in_ready is registered (no combinational path from out_ready) and is 1 whenever fewer than 2 beats are held. Throughput is 1 beat/cycle.
- Undefined: a single output register is used, with in_ready = !out_valid || out_ready (combinational).
- Data, round tagging and error behaviour are identical in both builds.

Verification
REQ-032 Single beat: in_first=1, state_in=00112233445566778899aabbccddeeff, round_key=000102030405060708090a0b0c0d0e0f -> next cycle out_valid=1, state_out=00102030405060708090a0b0c0d0e0f0, out_round=0, out_mix=0, out_last=0.
REQ-033 Full block, NR=10, 11 back-to-back beats with out_ready=1 -> out_round 0..10, out_mix=1 only for rounds 1..9, out_last=1 only on round 10, no idle cycle between beats.
REQ-034 Backpressure: out_ready=0 for 5 cycles mid-block -> outputs held stable, all 11 beats delivered in order.
- Skid build: exactly 2 beats are accepted during the stall.
REQ-035 Sequence errors:
- in_first=0 on the first beat after reset -> err_seq=1, out_round=0.
- in_first=1 at round 4 -> err_seq=1 and rc restarts at 0.
REQ-036 Reset asserted asynchronously at round 6 with out_valid=1 -> all outputs 0 immediately; a new block after reset starts at out_round=0.

Source files
------------

// File: rtl/inv_add_round_key.sv
// ---------------------------------------------------------------------------
// inv_add_round_key
//
// Final XOR stage of an AES inverse-cipher round pipeline. Each accepted beat
// carries one 128-bit state plus the round key for that round; the block
// XORs them, tags the result with its round index (0..NR) and tells the
// downstream stage whether InvMixColumns applies (rounds 1..NR-1) or whether
// the beat is the recovered plaintext (round NR).
//
// Round tracking is a two-state sequencer:
//   IDLE : waiting for the in_first beat of a new block
//   BUSY : rounds 1..NR of the current block still to come
// Out-of-order beats are never dropped; they are tagged as round 0 and raise
// the sticky err_seq flag, which only reset clears.
//
// Build option (macro INV_ARK_SKID_EN):
//   defined   - output register followed by a 2-entry skid buffer; in_ready
//               is a flop and has no combinational path from out_ready.
//   undefined - single output register; in_ready = !out_valid || out_ready.
// Data, round tagging and error behaviour are the same in both builds.
//
// NR must be 10, 12 or 14 (AES-128/192/256).
// ---------------------------------------------------------------------------
module inv_add_round_key #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out,
  output logic [3:0]   out_round,
  output logic         out_mix,
  output logic         out_last,
  output logic         err_seq
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  // One fully tagged output beat; byte 0 of data sits in bits [0:7].
  typedef struct packed {
    logic [0:127] data;
    logic [3:0]   round;
    logic         mix;
    logic         last;
  } beat_t;

  // -------------------------------------------------------------------------
  // Round sequencer
  // -------------------------------------------------------------------------
  seq_state_e state_q, state_d;
  logic [3:0] rc_q, rc_d;          // round index the next in-order beat carries
  logic       err_seq_q, err_seq_d;
  logic       accept;
  logic [3:0] beat_round;
  beat_t      in_beat;

  assign accept = in_valid && in_ready;

  // Tag the incoming beat and advance the round counter on acceptance.
  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    err_seq_d = err_seq_q;

    // A first beat always restarts at round 0; so does any beat in IDLE,
    // because there is no block in progress to place it in.
    beat_round = (in_first || state_q == ST_IDLE) ? 4'd0 : rc_q;

    if (accept) begin
      // in_first while a block is pending, or a non-first beat with no block
      // pending, are both sequence violations.
      if (in_first ? (state_q == ST_BUSY) : (state_q == ST_IDLE)) begin
        err_seq_d = 1'b1;
      end

      if (beat_round == NR_L) begin
        state_d = ST_IDLE;
        rc_d    = 4'd0;
      end else if (in_first || state_q == ST_BUSY) begin
        state_d = ST_BUSY;
        rc_d    = 4'(beat_round + 4'd1);
      end
      // A stray non-first beat in IDLE leaves the sequencer waiting for in_first.
    end

    in_beat.data  = state_in ^ round_key;
    in_beat.round = beat_round;
    in_beat.mix   = (beat_round != 4'd0) && (beat_round < NR_L);
    in_beat.last  = (beat_round == NR_L);
  end

  // Sequencer state and sticky error flag.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rc_q      <= 4'd0;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      err_seq_q <= err_seq_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output buffering
  // -------------------------------------------------------------------------
  beat_t out_q, out_d;
  logic  out_valid_q, out_valid_d;

`ifdef INV_ARK_SKID_EN

  // Output register plus a 2-entry skid FIFO that absorbs the beats which
  // arrive while in_ready (a flop) still reports space during a stall.
  beat_t      skid_q [2];
  beat_t      skid_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       out_free;
  logic       push;
  logic       pop;

  assign in_ready = in_ready_q;

  // Refill the output register from the skid FIFO first, then from the input.
  always_comb begin
    skid_d      = skid_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    out_free = !out_valid_q || out_ready;
    pop      = out_free && (count_q != 2'd0);
    // The input bypasses the FIFO only when the output slot frees up and
    // nothing older is waiting; otherwise it queues behind the older beats.
    push     = accept && !(out_free && count_q == 2'd0);

    if (out_free) begin
      if (count_q != 2'd0) begin
        out_d       = skid_q[rd_ptr_q];
        out_valid_d = 1'b1;
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push) begin
      skid_d[wr_ptr_q] = in_beat;
      wr_ptr_d         = ~wr_ptr_q;
    end

    count_d    = 2'(count_q + {1'b0, push} - {1'b0, pop});
    in_ready_d = (count_d < 2'd2);
  end

  // Output register, skid storage and registered in_ready.
  // NOTE: the two skid entries are reset as well so state_out reads 0 during
  // reset; at two entries that costs nothing worth avoiding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
    end
  end

`else

  // Single output register. ready_en_q keeps in_ready low through reset and
  // lets it rise on the first clock edge afterwards.
  logic ready_en_q, ready_en_d;

  assign in_ready = ready_en_q && (!out_valid_q || out_ready);

  // Load on acceptance, clear when the held beat is taken with nothing behind it.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ready_en_d  = 1'b1;

    if (accept) begin
      out_d       = in_beat;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ready_en_q  <= ready_en_d;
    end
  end

`endif

  assign out_valid = out_valid_q;
  assign state_out = out_q.data;
  assign out_round = out_q.round;
  assign out_mix   = out_q.mix;
  assign out_last  = out_q.last;
  assign err_seq   = err_seq_q;

endmodule

// File: tb/tb_inv_add_round_key.sv
// ---------------------------------------------------------------------------
// tb_inv_add_round_key
//
// Self-checking bench for inv_add_round_key (NR = 10). A block-level model
// (bytewise XOR plus a "which round comes next" counter) predicts every
// accepted beat; delivered beats are collected and compared in order.
// Expectations that depend on the INV_ARK_SKID_EN build are selected with
// the same macro.
// ---------------------------------------------------------------------------
module tb_inv_add_round_key;

  localparam int NR = 10;
`ifdef INV_ARK_SKID_EN
  localparam int EXP_STALL_ACC = 2;
`else
  localparam int EXP_STALL_ACC = 0;
`endif

  typedef struct packed {
    logic [0:127] data;
    logic [3:0]   round;
    logic         mix;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_first = 1'b0;
  logic [0:127] state_in = '0;
  logic [0:127] round_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] state_out;
  logic [3:0]   out_round;
  logic         out_mix;
  logic         out_last;
  logic         err_seq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];

  // Reference model state: is a block open, which round comes next, error seen.
  bit m_in_block;
  int m_next;
  bit m_err;

  inv_add_round_key #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .state_in  (state_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .out_round (out_round),
    .out_mix   (out_mix),
    .out_last  (out_last),
    .err_seq   (err_seq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void model_clear();
    m_in_block = 1'b0;
    m_next     = 0;
    m_err      = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endfunction

  // Predict the beat produced by one accepted input.
  function automatic beat_t model_accept(bit first, logic [0:127] s, logic [0:127] k);
    beat_t b;
    int    r;
    if (first) begin
      if (m_in_block) m_err = 1'b1;
      r          = 0;
      m_in_block = 1'b1;
      m_next     = 1;
    end else if (!m_in_block) begin
      m_err = 1'b1;
      r     = 0;
    end else begin
      r      = m_next;
      m_next = m_next + 1;
    end
    if (r == NR) m_in_block = 1'b0;
    for (int i = 0; i < 16; i++) b.data[8*i +: 8] = s[8*i +: 8] ^ k[8*i +: 8];
    b.round = 4'(r);
    b.mix   = (r >= 1) && (r <= NR - 1);
    b.last  = (r == NR);
    return b;
  endfunction

  // One clock cycle, entered and left at a falling edge. Records delivered
  // beats and feeds accepted beats to the model.
  task automatic step(input bit v, input bit f, input logic [0:127] s,
                      input logic [0:127] k, input bit ordy, output bit acc);
    in_valid  = v;
    in_first  = f;
    state_in  = s;
    round_key = k;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      got_q.push_back({state_out, out_round, out_mix, out_last});
      got_cyc.push_back(cyc);
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model_accept(f, s, k));
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    bit acc;
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++;
    if (state_out !== 128'h0) begin n_fail++; $display("FAIL reset_state_out got %h want 0", state_out); end
    n_checks++;
    if ({out_round, out_mix, out_last, err_seq} !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_tags got round=%0d mix=%b last=%b err=%b want all 0",
               out_round, out_mix, out_last, err_seq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    bit acc;
    step(1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff,
         128'h000102030405060708090a0b0c0d0e0f, 1'b1, acc);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_checks++;
    if (state_out !== 128'h00102030405060708090a0b0c0d0e0f0) begin
      n_fail++;
      $display("FAIL single_data got %h want 00102030405060708090a0b0c0d0e0f0", state_out);
    end
    n_checks++;
    if ({out_round, out_mix, out_last, err_seq} !== 7'h0) begin
      n_fail++;
      $display("FAIL single_tags got round=%0d mix=%b last=%b err=%b want 0/0/0/0",
               out_round, out_mix, out_last, err_seq);
    end
    drain(5);
    n_checks++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", got_q.size()); end
  endtask

  task automatic test_full_block();
    bit acc;
    int n_acc = 0;
    do_reset();
    for (int i = 0; i <= NR; i++) begin
      step(1'b1, i == 0, rand128(), rand128(), 1'b1, acc);
      if (acc) n_acc++;
    end
    drain(10);
    n_checks++;
    if (n_acc != NR + 1) begin n_fail++; $display("FAIL full_accept got %0d want %0d", n_acc, NR + 1); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < got_q.size() - 1; i++) begin
      n_checks++;
      if (got_cyc[i+1] != got_cyc[i] + 1) begin
        n_fail++;
        $display("FAIL full_bubble beat%0d got gap %0d want 1", i, got_cyc[i+1] - got_cyc[i]);
      end
    end
    n_checks++;
    if (err_seq !== 1'b0) begin n_fail++; $display("FAIL full_err got %b want 0", err_seq); end
  endtask

  task automatic test_backpressure();
    logic [0:127] s [NR+1];
    logic [0:127] k [NR+1];
    bit acc;
    int idx = 0;
    int t = 0;
    int stall_acc = 0;
    do_reset();
    for (int i = 0; i <= NR; i++) begin
      s[i] = rand128();
      k[i] = rand128();
    end
    while ((idx <= NR || got_q.size() < exp_q.size()) && t < 80) begin
      bit stall;
      stall = (t >= 4) && (t <= 8);
      if (idx <= NR) step(1'b1, idx == 0, s[idx], k[idx], !stall, acc);
      else           step(1'b0, 1'b0, '0, '0, !stall, acc);
      if (acc) begin
        idx++;
        if (stall) stall_acc++;
      end
      if (stall) begin
        n_checks++;
        if (exp_q.size() <= got_q.size() || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold_valid t=%0d got valid=%b want 1 with a pending beat", t, out_valid);
        end else if ({state_out, out_round, out_mix, out_last} !== exp_q[got_q.size()]) begin
          n_fail++;
          $display("FAIL bp_hold t=%0d got %h want %h", t,
                   {state_out, out_round, out_mix, out_last}, exp_q[got_q.size()]);
        end
      end
      t++;
    end
    n_checks++;
    if (stall_acc != EXP_STALL_ACC) begin
      n_fail++;
      $display("FAIL bp_stall_accept got %0d want %0d", stall_acc, EXP_STALL_ACC);
    end
    n_checks++;
    if (got_q.size() != NR + 1 || exp_q.size() != NR + 1) begin
      n_fail++;
      $display("FAIL bp_count got %0d delivered %0d predicted want %0d", got_q.size(), exp_q.size(), NR + 1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_seq_err();
    bit acc;
    // Non-first beat straight after reset.
    do_reset();
    step(1'b1, 1'b0, rand128(), rand128(), 1'b1, acc);
    n_checks++;
    if (out_valid !== 1'b1 || out_round !== 4'd0) begin
      n_fail++;
      $display("FAIL seq_nofirst_round got valid=%b round=%0d want 1/0", out_valid, out_round);
    end
    n_checks++;
    if (err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_nofirst_err got %b want 1", err_seq); end
    drain(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL seq_nofirst_beat got %0d beats want 1 matching the model", got_q.size());
    end
    // in_first again at round 4 of an open block.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, rand128(), rand128(), 1'b1, acc);
    n_checks++;
    if (err_seq !== 1'b0 || out_round !== 4'd3) begin
      n_fail++;
      $display("FAIL seq_pre got err=%b round=%0d want 0/3", err_seq, out_round);
    end
    step(1'b1, 1'b1, rand128(), rand128(), 1'b1, acc);
    n_checks++;
    if (err_seq !== 1'b1 || out_round !== 4'd0) begin
      n_fail++;
      $display("FAIL seq_restart got err=%b round=%0d want 1/0", err_seq, out_round);
    end
    step(1'b1, 1'b0, rand128(), rand128(), 1'b1, acc);
    n_checks++;
    if (out_round !== 4'd1 || out_mix !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_after got round=%0d mix=%b want 1/1", out_round, out_mix);
    end
    drain(5);
    n_checks++;
    if (got_q.size() != 6 || got_q != exp_q) begin
      n_fail++;
      $display("FAIL seq_stream got %0d beats want 6 matching the model", got_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    do_reset();
    for (int i = 0; i <= 6; i++) step(1'b1, i == 0, rand128(), rand128(), 1'b1, acc);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_round !== 4'd6) begin
      n_fail++;
      $display("FAIL async_pre got valid=%b round=%0d want 1/6", out_valid, out_round);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_round, out_mix, out_last, err_seq} !== 9'h0 || state_out !== 128'h0) begin
      n_fail++;
      $display("FAIL async_zero got valid=%b ready=%b round=%0d mix=%b last=%b err=%b data=%h want all 0",
               out_valid, in_ready, out_round, out_mix, out_last, err_seq, state_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    step(1'b1, 1'b1, rand128(), rand128(), 1'b1, acc);
    n_checks++;
    if (out_valid !== 1'b1 || out_round !== 4'd0 || err_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_restart got valid=%b round=%0d err=%b want 1/0/0", out_valid, out_round, err_seq);
    end
    drain(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL async_beat got %0d beats want 1 matching the model", got_q.size());
    end
  endtask

  task automatic test_back_to_back_random();
    bit acc;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      bit v;
      bit f;
      v = ($urandom_range(0, 3) != 0);
      if (!m_in_block) f = ($urandom_range(0, 19) != 0);
      else             f = ($urandom_range(0, 39) == 0);
      step(v, f, rand128(), rand128(), $urandom_range(0, 9) < 7, acc);
    end
    drain(20);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err_seq !== m_err) begin n_fail++; $display("FAIL rand_err got %b want %b", err_seq, m_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_block();
    test_backpressure();
    test_seq_err();
    test_async_reset();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
